mem_slot_rr_arbiter: RTL

Round-robin, time-sliced arbiter that shares a single memory-controller command port between N_REQ requesters. Each grant lasts until the owner signals `done`, drops its request, or exhausts a SLOT_MAX-cycle quantum. Rotation is fair: after a release, the search starts at the requester following the previous owner. It sits between the requester front-ends and the memory command datapath, and drives the datapath's input-select through `grant_id`.

---
 rtl/mem_slot_rr_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/mem_slot_rr_arbiter.sv
// mem_slot_rr_arbiter: time-sliced round-robin arbiter for a shared memory command port.
// Each grant is held until the owner pulses done, drops its request, or uses up a
// SLOT_MAX-cycle quantum. After a release, the search starts at the requester that
// follows the previous owner.
// Optional build macro: ARB_TURNAROUND_EN inserts one dead cycle (TURN) after every release.
module mem_slot_rr_arbiter #(
    parameter int unsigned  N_REQ    = 4,
    parameter int unsigned  SLOT_MAX = 16,
    localparam int unsigned ID_W     = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] done,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_id,
    output logic             busy,
    output logic             preempt
);

    localparam int unsigned CNT_W = $clog2(SLOT_MAX);
    localparam int unsigned SUM_W = ID_W + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
`ifdef ARB_TURNAROUND_EN
    localparam logic [1:0] ST_TURN  = 2'd2;
`endif

    logic [1:0]       state_q,    state_d;
    logic [N_REQ-1:0] grant_q,    grant_d;
    logic [ID_W-1:0]  grant_id_q, grant_id_d;
    logic             busy_q,     busy_d;
    logic             preempt_q,  preempt_d;
    logic [ID_W-1:0]  rr_ptr_q,   rr_ptr_d;
    logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;

    logic             own_done_c;
    logic             own_req_c;
    logic             at_limit_c;
    logic             release_c;
    logic             expire_c;
    logic [ID_W-1:0]  next_ptr_c;
    logic [ID_W-1:0]  search_ptr_c;
    logic [SUM_W-1:0] cand_c;
    logic             pick_valid_c;
    logic [ID_W-1:0]  pick_id_c;

    // Owner status, release causes and the post-release rotation pointer
    always_comb begin
        own_done_c   = done[grant_id_q];
        own_req_c    = req[grant_id_q];
        at_limit_c   = (slot_cnt_q == CNT_W'(SLOT_MAX - 1));
        release_c    = own_done_c | ~own_req_c | at_limit_c;
        expire_c     = at_limit_c & own_req_c & ~own_done_c;
        next_ptr_c   = (grant_id_q == ID_W'(N_REQ - 1)) ? '0 : grant_id_q + ID_W'(1);
        search_ptr_c = (state_q == ST_GRANT) ? next_ptr_c : rr_ptr_q;
    end

    // Circular first-set search starting at search_ptr_c; the releasing owner is naturally last
    always_comb begin
        pick_valid_c = 1'b0;
        pick_id_c    = '0;
        cand_c       = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand_c = SUM_W'(search_ptr_c) + SUM_W'(i);
            if (cand_c >= SUM_W'(N_REQ)) begin
                cand_c = cand_c - SUM_W'(N_REQ);
            end
            if (!pick_valid_c && req[cand_c[ID_W-1:0]]) begin
                pick_valid_c = 1'b1;
                pick_id_c    = cand_c[ID_W-1:0];
            end
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        busy_d     = busy_q;
        preempt_d  = 1'b0;
        rr_ptr_d   = rr_ptr_q;
        slot_cnt_d = slot_cnt_q;

        case (state_q)
            ST_GRANT: begin
                if (release_c) begin
                    rr_ptr_d   = next_ptr_c;
                    preempt_d  = expire_c;
                    slot_cnt_d = '0;
`ifdef ARB_TURNAROUND_EN
                    state_d    = ST_TURN;
                    grant_d    = '0;
                    busy_d     = 1'b0;
`else
                    if (pick_valid_c) begin
                        state_d    = ST_GRANT;
                        grant_d    = N_REQ'(1) << pick_id_c;
                        grant_id_d = pick_id_c;
                        busy_d     = 1'b1;
                    end else begin
                        state_d    = ST_IDLE;
                        grant_d    = '0;
                        busy_d     = 1'b0;
                    end
`endif
                end else begin
                    slot_cnt_d = slot_cnt_q + CNT_W'(1);
                end
            end
            // IDLE, TURN and any unexpected encoding arbitrate from rr_ptr_q
            default: begin
                if (pick_valid_c) begin
                    state_d    = ST_GRANT;
                    grant_d    = N_REQ'(1) << pick_id_c;
                    grant_id_d = pick_id_c;
                    busy_d     = 1'b1;
                    slot_cnt_d = '0;
                end else begin
                    state_d    = ST_IDLE;
                    grant_d    = '0;
                    busy_d     = 1'b0;
                end
            end
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            grant_id_q <= '0;
            busy_q     <= 1'b0;
            preempt_q  <= 1'b0;
            rr_ptr_q   <= '0;
            slot_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            busy_q     <= busy_d;
            preempt_q  <= preempt_d;
            rr_ptr_q   <= rr_ptr_d;
            slot_cnt_q <= slot_cnt_d;
        end
    end

    assign grant    = grant_q;
    assign grant_id = grant_id_q;
    assign busy     = busy_q;
    assign preempt  = preempt_q;

endmodule
